// File: rtl/sobel_sdram_pkg.sv
// Shared types and default sizing for the Sobel SDRAM write path.
package sobel_sdram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    REQ,
    BURST,
    LAST
  } state_t;

  localparam int unsigned DEF_FRAME_WORDS = 153600;
  localparam int unsigned DEF_BURST_LEN   = 256;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, single clock, registered read port.
// The read register only updates on a read, so it holds between reads.
module sdp_ram #(
  parameter int unsigned WD    = 16,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WD-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [WD-1:0] rdata
);

  logic [WD-1:0] mem [DEPTH];

  // Write port: storage has no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered data, cleared on reset, held when idle.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sobel_sdram_writer.sv
// Drains the Sobel byte FIFO, packs pixel pairs into SDRAM words, stages one
// burst locally and writes it to SDRAM at incrementing frame addresses.
module sobel_sdram_writer
  import sobel_sdram_pkg::*;
#(
  parameter int unsigned DATA_WD     = 8,
  parameter int unsigned WORD_WD     = 16,
  parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int unsigned ADDR_WD     = 22,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned CNT_WD      = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [CNT_WD-1:0]  fifo_cnt_i,
  input  logic [DATA_WD-1:0] fifo_data_i,
  output logic               fifo_rd_o,
  output logic               wr_req_o,
  output logic [ADDR_WD-1:0] wr_addr_o,
  input  logic               wr_ack_i,
  input  logic               wr_data_req_i,
  output logic [WORD_WD-1:0] wr_data_o,
  output logic               busy_o,
  output logic               frame_done_o
);

  localparam int unsigned PTR_WD  = $clog2(BURST_LEN);
  localparam int unsigned BEAT_WD = PTR_WD + 1;
  localparam int unsigned FC_WD   = $clog2(2 * BURST_LEN + 2);

  localparam logic [FC_WD-1:0]   RD_LAST     = FC_WD'(2 * BURST_LEN - 1);
  localparam logic [FC_WD-1:0]   FILL_END    = FC_WD'(2 * BURST_LEN + 1);
  localparam logic [CNT_WD:0]    FILL_THRESH = (CNT_WD + 1)'(2 * BURST_LEN);
  localparam logic [PTR_WD-1:0]  PTR_LAST    = PTR_WD'(BURST_LEN - 1);
  localparam logic [ADDR_WD-1:0] STEP        = ADDR_WD'(BURST_LEN);
  localparam logic [ADDR_WD-1:0] FRAME_END   = ADDR_WD'(FRAME_WORDS);
  localparam logic [ADDR_WD-1:0] BASE        = ADDR_WD'(BASE_ADDR);

  state_t              state;
  logic [FC_WD-1:0]    fill_cnt;
  logic [ADDR_WD-1:0]  offset;
  logic [ADDR_WD-1:0]  next_offset;
  logic [PTR_WD-1:0]   rd_ptr;

  logic                rd_q;
  logic [BEAT_WD-1:0]  beat;
  logic [DATA_WD-1:0]  lo_q;

  logic                ram_we;
  logic [PTR_WD-1:0]   ram_waddr;
  logic [WORD_WD-1:0]  ram_wdata;
  logic                ram_re;

  assign next_offset = offset + STEP;

  // Odd beats complete a word: current byte is high, held even byte is low.
  always_comb begin
    ram_we    = rd_q & beat[0];
    ram_waddr = beat[BEAT_WD-1:1];
    ram_wdata = {fifo_data_i, lo_q};
    ram_re    = (state == BURST) & wr_data_req_i;
  end

  // Capture side: FIFO data lags fifo_rd_o by one cycle, tracked by rd_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= 1'b0;
      beat <= '0;
    end else begin
      rd_q <= fifo_rd_o;
      if (state == IDLE) beat <= '0;
      else if (rd_q)     beat <= beat + 1'b1;
    end
    if (rd_q && !beat[0]) lo_q <= fifo_data_i;
  end

  // Main control FSM with registered outputs.
  // FILL runs one cycle past the last capture so the request rises
  // 2*BURST_LEN+2 cycles after leaving IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      fill_cnt     <= '0;
      offset       <= '0;
      rd_ptr       <= '0;
      fifo_rd_o    <= 1'b0;
      wr_req_o     <= 1'b0;
      wr_addr_o    <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (en_i && ({1'b0, fifo_cnt_i} >= FILL_THRESH)) begin
            state     <= FILL;
            busy_o    <= 1'b1;
            fifo_rd_o <= 1'b1;
            fill_cnt  <= '0;
          end
        end
        FILL: begin
          fill_cnt  <= fill_cnt + 1'b1;
          fifo_rd_o <= (fill_cnt < RD_LAST);
          if (fill_cnt == FILL_END) begin
            state     <= REQ;
            wr_req_o  <= 1'b1;
            wr_addr_o <= BASE + offset;
          end
        end
        REQ: begin
          if (wr_ack_i) begin
            state    <= BURST;
            wr_req_o <= 1'b0;
            rd_ptr   <= '0;
          end
        end
        BURST: begin
          if (wr_data_req_i) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_ptr == PTR_LAST) state <= LAST;
          end
        end
        LAST: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          if (next_offset == FRAME_END) begin
            offset       <= '0;
            frame_done_o <= 1'b1;
          end else begin
            offset <= next_offset;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  sdp_ram #(
    .WD    (WORD_WD),
    .DEPTH (BURST_LEN),
    .AW    (PTR_WD)
  ) u_stage (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (wr_data_o)
  );

endmodule

// File: tb/tb_sobel_sdram_writer.sv
// Scoreboard bench for sobel_sdram_writer with a 4-word burst, 8-word frame.
module tb_sobel_sdram_writer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic [11:0] fifo_cnt_i = '0;
  logic [7:0]  fifo_data_i = '0;
  logic        fifo_rd_o;
  logic        wr_req_o;
  logic [21:0] wr_addr_o;
  logic        wr_ack_i = 1'b0;
  logic        wr_data_req_i = 1'b0;
  logic [15:0] wr_data_o;
  logic        busy_o;
  logic        frame_done_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo_q [$];
  logic [15:0] word_q [$];
  logic [21:0] addr_q [$];

  logic [15:0] last_word = '0;
  logic [21:0] cur_addr = '0;
  bit in_burst = 0, chk_pending = 0, rd_seen = 0;
  bit req_prev = 0, busy_prev = 0, fd_prev = 0, ack_prev = 0;
  int cyc = 0, t_busy = 0, rd_count = 0, fd_count = 0;

  sobel_sdram_writer #(
    .DATA_WD     (8),
    .WORD_WD     (16),
    .BURST_LEN   (4),
    .FRAME_WORDS (8),
    .ADDR_WD     (22),
    .BASE_ADDR   (32'h100),
    .CNT_WD      (12)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .fifo_cnt_i    (fifo_cnt_i),
    .fifo_data_i   (fifo_data_i),
    .fifo_rd_o     (fifo_rd_o),
    .wr_req_o      (wr_req_o),
    .wr_addr_o     (wr_addr_o),
    .wr_ack_i      (wr_ack_i),
    .wr_data_req_i (wr_data_req_i),
    .wr_data_o     (wr_data_o),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: a read seen in one cycle yields the next byte in the following cycle.
  always begin
    @(posedge clk);
    if (rd_seen) begin
      #1;
      if (fifo_q.size() > 0) fifo_data_i = fifo_q.pop_front();
      else                   fifo_data_i = 8'hEE;
    end
  end

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge clk) begin
    cyc++;
    rd_seen = fifo_rd_o;
    if (rst_i) begin
      chk_pending = 0;
      req_prev    = 0;
      busy_prev   = 0;
      fd_prev     = 0;
      ack_prev    = 0;
    end else begin
      if (chk_pending) begin
        if (word_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL data_extra: got 0x%0h expected no word", wr_data_o);
        end else begin
          last_word = word_q.pop_front();
          check("wr_data", 32'(wr_data_o), 32'(last_word));
        end
      end else begin
        check("wr_data_hold", 32'(wr_data_o), 32'(last_word));
      end
      chk_pending = wr_data_req_i && in_burst;

      if (busy_o && !busy_prev) begin
        t_busy   = cyc;
        rd_count = 0;
        check("rd_start", 32'(fifo_rd_o), 32'd1);
      end
      if (fifo_rd_o) rd_count++;

      if (wr_req_o && !req_prev) begin
        check("req_latency", 32'(cyc - t_busy), 32'd10);
        check("rd_count", 32'(rd_count), 32'd8);
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL addr_extra: got 0x%0h expected no request", wr_addr_o);
        end else begin
          cur_addr = addr_q.pop_front();
        end
      end
      if (wr_req_o) check("wr_addr", 32'(wr_addr_o), 32'(cur_addr));
      if (!wr_req_o && req_prev) check("req_drop_needs_ack", 32'(ack_prev), 32'd1);

      if (frame_done_o) begin
        fd_count++;
        check("frame_done_width", 32'(fd_prev), 32'd0);
      end

      ack_prev  = wr_ack_i;
      req_prev  = wr_req_o;
      busy_prev = busy_o;
      fd_prev   = frame_done_o;
    end
  end

  task automatic wait_level(input int sel, input logic val, input int limit, input string name);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (((sel == 0) ? busy_o : wr_req_o) == val) begin
        ok = 1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // One burst: load FIFO, start, ack after a delay, strobe with gaps,
  // optionally reset after rst_after strobes.
  task automatic run_burst(input logic [63:0] bytes, input logic [63:0] words,
                           input logic [21:0] addr, input int gap, input int ack_delay,
                           input bit spurious, input int rst_after);
    int n;
    n = (rst_after < 4) ? rst_after : 4;
    for (int i = 0; i < 8; i++) fifo_q.push_back(bytes[8*i +: 8]);
    for (int i = 0; i < n; i++) word_q.push_back(words[16*i +: 16]);
    addr_q.push_back(addr);

    @(posedge clk); #1;
    fifo_cnt_i = 12'd8;
    en_i = 1'b1;
    wait_level(0, 1'b1, 5, "busy_rise_timeout");
    en_i = 1'b0;
    wait_level(1, 1'b1, 20, "req_rise_timeout");

    for (int d = 0; d < ack_delay; d++) begin
      @(posedge clk); #1;
      wr_data_req_i = spurious && (d == 2);
    end
    @(posedge clk); #1;
    wr_data_req_i = 1'b0;
    wr_ack_i = 1'b1;
    in_burst = 1;
    @(posedge clk); #1;
    wr_ack_i = 1'b0;
    check("req_after_ack", 32'(wr_req_o), 32'd0);

    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      wr_data_req_i = 1'b1;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        wr_data_req_i = 1'b0;
      end
    end
    @(posedge clk); #1;
    wr_data_req_i = 1'b0;
    in_burst = 0;

    if (rst_after < 4) begin
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(posedge clk); #1;
      check("rst_wr_req", 32'(wr_req_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_wr_data", 32'(wr_data_o), 32'd0);
      rst_i = 1'b0;
      word_q.delete();
      fifo_q.delete();
      last_word = '0;
    end else begin
      wait_level(0, 1'b0, 10, "busy_fall_timeout");
      repeat (2) @(posedge clk);
      #1;
      check("words_consumed", 32'(word_q.size()), 32'd0);
    end
    fifo_cnt_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("reset_fifo_rd", 32'(fifo_rd_o), 32'd0);
    check("reset_wr_req", 32'(wr_req_o), 32'd0);
    check("reset_wr_addr", 32'(wr_addr_o), 32'd0);
    check("reset_wr_data", 32'(wr_data_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_frame_done", 32'(frame_done_o), 32'd0);

    // One byte short of a burst, plus a stray ack: must stay idle.
    en_i = 1'b1;
    fifo_cnt_i = 12'd7;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      wr_ack_i = (i == 3);
      check("idle_fifo_rd", 32'(fifo_rd_o), 32'd0);
      check("idle_busy", 32'(busy_o), 32'd0);
    end
    wr_ack_i = 1'b0;
    en_i = 1'b0;

    run_burst(64'h8877665544332211, 64'h8877_6655_4433_2211, 22'h100, 0, 0, 0, 4);
    check("frame_done_count_1", 32'(fd_count), 32'd0);
    run_burst(64'hA7A6A5A4A3A2A1A0, 64'hA7A6_A5A4_A3A2_A1A0, 22'h104, 2, 0, 0, 4);
    check("frame_done_count_2", 32'(fd_count), 32'd1);
    run_burst(64'hEFCDAB8967452301, 64'hEFCD_AB89_6745_2301, 22'h100, 0, 10, 1, 4);
    check("frame_done_count_3", 32'(fd_count), 32'd1);
    run_burst(64'hF7F6F5F4F3F2F1F0, 64'hF7F6_F5F4_F3F2_F1F0, 22'h104, 0, 0, 0, 2);
    run_burst(64'h6996F00FC33CA55A, 64'h6996_F00F_C33C_A55A, 22'h100, 1, 0, 0, 4);
    check("frame_done_count_5", 32'(fd_count), 32'd1);
    check("addr_queue_empty", 32'(addr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
